// File: rtl/signed_seg_display.sv
// Shows a latched 4-bit two's-complement value in sign-magnitude form on a
// 4-digit common-anode 7-segment display, time-multiplexed by a refresh counter.
module signed_seg_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] value,
  input  logic       load,
  input  logic       disp_en,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int             CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [6:0]     SEG_OFF = 7'h7F;
  localparam logic [6:0]     SEG_MIN = 7'b0111111;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic signed [3:0]  hold_q, hold_d;
  logic [6:0]         seg_q, seg_d;
  logic [3:0]         an_scan_q, an_scan_d;
  logic [3:0]         an_q, an_d;

  logic               tick;
  logic               neg;
  logic [3:0]         hold_u;
  logic [3:0]         mag;

  function automatic logic [6:0] glyph(input logic [3:0] m);
    case (m)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      default: glyph = SEG_OFF;
    endcase
  endfunction

  function automatic logic [3:0] anode(input state_t s);
    case (s)
      DIG0:    anode = 4'b1110;
      DIG1:    anode = 4'b1101;
      DIG2:    anode = 4'b1011;
      default: anode = 4'b0111;
    endcase
  endfunction

  function automatic logic [6:0] digit_seg(input state_t s, input logic n,
                                           input logic [3:0] m);
    case (s)
      DIG0:    digit_seg = glyph(m);
      DIG1:    digit_seg = n ? SEG_MIN : SEG_OFF;
      default: digit_seg = SEG_OFF;
    endcase
  endfunction

  // Sign/magnitude; -8 negates to 4'b1000, which reads as unsigned 8.
  always_comb begin
    hold_u = hold_q;
    neg    = hold_u[3];
    mag    = neg ? (~hold_u + 4'd1) : hold_u;
  end

  always_comb begin
    tick   = (cnt_q == CNT_MAX);
    cnt_d  = tick ? '0 : cnt_q + CW'(1);
    hold_d = load ? $signed(value) : hold_q;
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        DIG0:    state_d = DIG1;
        DIG1:    state_d = DIG2;
        DIG2:    state_d = DIG3;
        default: state_d = DIG0;
      endcase
    end
  end

  // Glyph and anode are sampled only on a tick, from the pre-load hold value;
  // disp_en masks the registered anodes without disturbing the scan.
  always_comb begin
    seg_d     = seg_q;
    an_scan_d = an_scan_q;
    if (tick) begin
      seg_d     = digit_seg(state_d, neg, mag);
      an_scan_d = anode(state_d);
    end
    an_d = disp_en ? an_scan_d : 4'hF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= DIG0;
      cnt_q     <= '0;
      hold_q    <= '0;
      seg_q     <= SEG_OFF;
      an_scan_q <= 4'hF;
      an_q      <= 4'hF;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      seg_q     <= seg_d;
      an_scan_q <= an_scan_d;
      an_q      <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_signed_seg_display.sv
// Bench for signed_seg_display (REFRESH_DIV=4): directed scenarios plus random
// load/enable/reset traffic scored every cycle against a slot-level model.
module tb_signed_seg_display;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] value;
  logic       load;
  logic       disp_en;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int n_chk  = 0;
  int n_pass = 0;
  bit sb_on  = 1'b0;

  signed_seg_display #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .disp_en(disp_en),
    .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph_tbl [0:8] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                  7'b0110000, 7'b0011001, 7'b0010010,
                                  7'b0000010, 7'b1111000, 7'b0000000};
  logic [3:0] pats [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: elapsed cycles in the slot, current digit index, and the
  // held value as a plain signed integer.
  int         m_cnt, m_dig, m_hold;
  logic [6:0] e_seg;
  logic [3:0] e_scan, e_an;

  always @(posedge clk) begin
    int nd, mg;
    logic [6:0] ns;
    logic [3:0] nsc;
    if (reset) begin
      m_cnt <= 0; m_dig <= 0; m_hold <= 0;
      e_seg <= 7'h7F; e_scan <= 4'hF; e_an <= 4'hF;
    end else begin
      ns = e_seg; nsc = e_scan; nd = m_dig;
      if (m_cnt == DIV - 1) begin
        nd  = (m_dig + 1) % 4;
        mg  = (m_hold < 0) ? -m_hold : m_hold;
        if (nd == 0)      ns = glyph_tbl[mg];
        else if (nd == 1) ns = (m_hold < 0) ? 7'b0111111 : 7'h7F;
        else              ns = 7'h7F;
        nsc = pats[nd];
      end
      m_dig  <= nd;
      m_cnt  <= (m_cnt == DIV - 1) ? 0 : m_cnt + 1;
      e_seg  <= ns;
      e_scan <= nsc;
      e_an   <= disp_en ? nsc : 4'hF;
      if (load) m_hold <= int'($signed(value));
    end
  end

  always @(negedge clk) begin
    if (sb_on) begin
      chk("sb_seg", seg, e_seg);
      chk("sb_an", an, e_an);
      chk("sb_dp", dp, 1'b1);
    end
  end

  task automatic reset_seq(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    sb_on = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_an", an, 4'hF);
    end
    @(negedge clk);
    chk("first_an", an, 4'b1101);
    chk("first_seg", seg, 7'h7F);
  endtask

  task automatic do_load(input logic [3:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  // Waits for the first cycle of the next slot whose anodes equal pat.
  task automatic wait_slot(input logic [3:0] pat);
    int n = 0;
    while (an == pat && n < 60) begin @(negedge clk); n++; end
    while (an != pat && n < 60) begin @(negedge clk); n++; end
    if (n >= 60) begin
      n_chk++;
      $display("FAIL wait_slot timeout: an=%b required %b", an, pat);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; load = 1'b0; value = 4'd0; disp_en = 1'b1;
    reset_seq(3);

    do_load(4'b0101);
    wait_slot(4'b1110); chk("pos5_mag", seg, 7'b0010010);
    wait_slot(4'b1101); chk("pos5_sign", seg, 7'h7F);

    do_load(4'b1101);
    wait_slot(4'b1110); chk("neg3_mag", seg, 7'b0110000);
    wait_slot(4'b1101); chk("neg3_sign", seg, 7'b0111111);

    do_load(4'b1000);
    wait_slot(4'b1110); chk("neg8_mag", seg, 7'b0000000);
    for (int d = 0; d < 4; d++) begin
      chk("scan_an", an, pats[d]);
      if (d == 1) chk("neg8_sign", seg, 7'b0111111);
      n = 0;
      while (an == pats[d] && n < 20) begin @(negedge clk); n++; end
      chk("slot_len", n, DIV);
    end

    do_load(4'b0010);
    wait_slot(4'b0111);
    repeat (DIV - 1) @(negedge clk);
    do_load(4'b0111);
    chk("coll_an", an, 4'b1110);
    chk("coll_old", seg, 7'b0100100);
    wait_slot(4'b1110); chk("coll_new", seg, 7'b1111000);

    repeat (2) @(negedge clk);
    disp_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("dis_an", an, 4'hF);
    end
    disp_en = 1'b1;
    @(negedge clk);
    chk("reen_an", an, e_scan);

    wait_slot(4'b1011);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_seg", seg, 7'h7F);
    chk("mid_rst_an", an, 4'hF);
    reset_seq(1);

    for (int i = 0; i < 600; i++) begin
      value   = 4'($urandom);
      load    = ($urandom_range(0, 7) == 0);
      disp_en = ($urandom_range(0, 9) != 0);
      reset   = ($urandom_range(0, 149) == 0);
      @(negedge clk);
    end
    load = 1'b0; disp_en = 1'b1;
    reset_seq(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
